multi_strobe_gen: RTL and testbench
===================================

Name: multi_strobe_gen

Overview:
- Parametrised successor to the fixed three-output strobe divider.
- Generates NUM_CH independent strobe channels from sysClk. Each channel has a runtime-programmable divisor, an enable, and a pulse or square output mode.
- Divisor updates are shadowed so an update never truncates the period in progress, and a global sync aligns all channel phases.
- Feeds the slow/init/read timing strobes of the RAM and video datapath.

Parameters:
- NUM_CH, 4, number of strobe channels (1..16).
- CNT_W, 12, divisor and counter width in bits.
- DEF_DIV, 2500, divisor loaded into every channel at reset (must be < 2^CNT_W).

Ports:
- sysClk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- cfgWe  in  1  single-cycle config write strobe.
- cfgCh  in  $clog2(NUM_CH) (min 1)  channel to configure; a value >= NUM_CH makes the write ignored.
- cfgDiv  in  CNT_W  new divisor.
- cfgMode  in  1  0 = pulse output, 1 = square (toggle) output.
- cfgEn  in  1  channel enable.
- cfgNow  in  1  1 = apply immediately and restart the counter; 0 = shadow the divisor until the next terminal count.
- syncAll  in  1  clears all counters and square outputs on the same edge.
- strobe  out  NUM_CH  per-channel output, registered.
- pending  out  NUM_CH  shadowed divisor not yet applied.

Behaviour:
- Reset (async, on rst high):
  - every channel: div = DEF_DIV, shadow = DEF_DIV, cnt = 0, en = 0, mode = 0.
  - strobe = 0, pending = 0.
- Per channel, each posedge, when en = 1 and div >= 1:
  - If cnt == div-1 (terminal count): cnt <= 0, and tc = 1 for that cycle.
  - Otherwise: cnt <= cnt + 1.
- Output timing:
  - Pulse mode: strobe <= tc. The output is high for exactly 1 cycle every div cycles.
  - Square mode: strobe toggles on each tc, giving a period of 2*div cycles at 50% duty.
  - First event: with a counter starting at 0, strobe first rises div edges after en takes effect.
- div == 1: tc every cycle.
  - Pulse mode: strobe is constantly 1.
  - Square mode: strobe toggles every cycle.
- div == 0: the channel is stalled. cnt is held at 0, strobe <= 0 in pulse mode, and the square level is held.
- en = 0: cnt is held, strobe <= 0 in pulse mode, and the square level is held. Re-enabling resumes from the held cnt.
- Config write (cfgWe = 1, cfgCh valid):
  - en and mode are updated on that edge.
  - A mode change clears the square level to 0.
- Divisor write, cfgNow = 1:
  - div <= cfgDiv, shadow <= cfgDiv, cnt <= 0, pending cleared.
  - No tc on that edge.
- Divisor write, cfgNow = 0:
  - shadow <= cfgDiv and pending <= 1.
  - At the next tc, div <= shadow and pending <= 0; the new period starts from cnt = 0.
  - If the channel is disabled or div == 0, the shadow applies on the write edge instead.
- A second shadowed write before tc overwrites the shadow; only the last value applies.
- Write coinciding with tc:
  - cfgNow = 0: the tc uses the old div and the new shadow applies at the following tc. pending stays 1.
  - cfgNow = 1: the write wins and no tc is produced.
- syncAll:
  - On that edge, all cnt <= 0 and all square levels <= 0.
  - Suppresses tc on that edge and has priority over cfgNow.
  - pending shadows are kept.
  - Enabled channels with equal div then strobe on the same cycle.
- Reset mid-operation: an immediate async return to reset values. Pending shadows are discarded.
- Arithmetic: the counter compare is unsigned, CNT_W wide, with no overflow possible because cnt <= div-1. div = 2^CNT_W-1 is legal.

Decomposition:
- Shared package strobe_pkg: mode encodings (MODE_PULSE = 0, MODE_SQUARE = 1) and the channel-index width function.
- Sub-module strobe_chan holds one channel's div/shadow/cnt/en/mode/level and its tc logic.
- The top level instantiates NUM_CH copies with a generate loop, decodes cfgCh into per-channel write enables, and fans out syncAll.

Test Plan:
- Reset then enable ch0 with div=4, pulse mode, cfgNow=1 -> strobe[0] high 1 cycle at edges 4, 8, 12 after the write; strobe[3:1] stay 0 and pending = 0.
- ch1: div=3, square mode -> strobe[1] toggles every 3 cycles (period 6); then write div=0 -> strobe[1] frozen at its current level, cnt held.
- ch2: div=5 running; shadowed write div=2 at cnt=1 -> pending[2]=1, remaining pulses stay 5 apart, after the next tc pulses come every 2 cycles, pending[2]=0.
- ch0: div=4, ch1: div=4, started 2 cycles apart -> syncAll pulse -> both strobe on the same cycle, 4 cycles after the sync edge.
- Shadowed write exactly on a tc edge -> tc still uses the old div, new div starts after the next tc. cfgNow write on a tc edge -> no strobe that cycle, count restarts.
- Assert rst mid-count with a shadow pending -> strobe = 0 and pending = 0 immediately. After release with en = 0 there is no strobe; enabling shows period DEF_DIV=2500.

Source files
------------

// File: rtl/strobe_pkg.sv
// Shared definitions for the multi-channel strobe generator:
// output mode encodings and the channel-index width helper.
package strobe_pkg;

    typedef enum logic {
        MODE_PULSE  = 1'b0,
        MODE_SQUARE = 1'b1
    } mode_e;

    // Width of a channel index, never narrower than one bit.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/strobe_chan.sv
// One strobe channel: divisor, shadow divisor, counter, enable, mode,
// square level and the terminal-count logic that drives the output.
module strobe_chan
    import strobe_pkg::*;
#(
    parameter int CNT_W   = 12,
    parameter int DEF_DIV = 2500
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic             mode_i,
    input  logic             en_i,
    input  logic             now_i,
    input  logic             sync_i,
    output logic             strobe_o,
    output logic             pending_o
);

    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    mode_e            mode_q, mode_d;
    logic             lvl_q, lvl_d;
    logic             pend_q, pend_d;
    logic             str_q, str_d;

    logic             run;
    logic             term;
    logic             tc;

    // Next-state: count, terminal count, config writes, then sync override.
    always_comb begin
        div_d  = div_q;
        shd_d  = shd_q;
        cnt_d  = cnt_q;
        en_d   = en_q;
        mode_d = mode_q;
        lvl_d  = lvl_q;
        pend_d = pend_q;

        run  = en_q && (div_q != '0);
        term = run && (cnt_q == div_q - CNT_W'(1));
        tc   = term && !sync_i && !(we_i && now_i);

        if (run) begin
            cnt_d = term ? '0 : cnt_q + CNT_W'(1);
        end else if (div_q == '0) begin
            cnt_d = '0;
        end

        // A shadow written on this very edge waits for the next tc.
        if (tc) begin
            lvl_d = ~lvl_q;
            if (pend_q && !we_i) begin
                div_d  = shd_q;
                pend_d = 1'b0;
            end
        end

        // A new divisor on an idle channel always starts a fresh period.
        if (we_i) begin
            en_d   = en_i;
            mode_d = mode_e'(mode_i);
            if (mode_d != mode_q) begin
                lvl_d = 1'b0;
            end
            shd_d = div_i;
            if (now_i || !run) begin
                div_d  = div_i;
                cnt_d  = '0;
                pend_d = 1'b0;
            end else begin
                pend_d = 1'b1;
            end
        end

        if (sync_i) begin
            cnt_d = '0;
            lvl_d = 1'b0;
        end

        str_d = (mode_d == MODE_SQUARE) ? lvl_d : tc;
    end

    // Channel state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q  <= CNT_W'(DEF_DIV);
            shd_q  <= CNT_W'(DEF_DIV);
            cnt_q  <= '0;
            en_q   <= 1'b0;
            mode_q <= MODE_PULSE;
            lvl_q  <= 1'b0;
            pend_q <= 1'b0;
            str_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            shd_q  <= shd_d;
            cnt_q  <= cnt_d;
            en_q   <= en_d;
            mode_q <= mode_d;
            lvl_q  <= lvl_d;
            pend_q <= pend_d;
            str_q  <= str_d;
        end
    end

    assign strobe_o  = str_q;
    assign pending_o = pend_q;

endmodule

// File: rtl/multi_strobe_gen.sv
// NUM_CH independent programmable strobe channels with shadowed
// divisor updates and a global phase-alignment sync.
module multi_strobe_gen
    import strobe_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 12,
    parameter int DEF_DIV = 2500
) (
    input  logic                          sysClk,
    input  logic                          rst,
    input  logic                          cfgWe,
    input  logic [ch_idx_w(NUM_CH)-1:0]   cfgCh,
    input  logic [CNT_W-1:0]              cfgDiv,
    input  logic                          cfgMode,
    input  logic                          cfgEn,
    input  logic                          cfgNow,
    input  logic                          syncAll,
    output logic [NUM_CH-1:0]             strobe,
    output logic [NUM_CH-1:0]             pending
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic we;

        // Out-of-range channel numbers match no channel.
        assign we = cfgWe && (32'(cfgCh) == 32'(i));

        strobe_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk_i     (sysClk),
            .rst_i     (rst),
            .we_i      (we),
            .div_i     (cfgDiv),
            .mode_i    (cfgMode),
            .en_i      (cfgEn),
            .now_i     (cfgNow),
            .sync_i    (syncAll),
            .strobe_o  (strobe[i]),
            .pending_o (pending[i])
        );
    end

endmodule

// File: tb/tb_multi_strobe_gen.sv
// Self-checking bench for multi_strobe_gen: directed scenarios with
// hand-derived timing plus a randomized run against a cycle model.
module tb_multi_strobe_gen;

    localparam int NCH = 4;

    logic        sysClk;
    logic        rst;
    logic        cfgWe;
    logic [1:0]  cfgCh;
    logic [11:0] cfgDiv;
    logic        cfgMode;
    logic        cfgEn;
    logic        cfgNow;
    logic        syncAll;
    logic [3:0]  strobe;
    logic [3:0]  pending;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: period length, cycles elapsed in the period,
    // shadow value and flags per channel.
    int   m_div [NCH];
    int   m_shd [NCH];
    int   m_age [NCH];
    bit   m_en  [NCH];
    bit   m_sq  [NCH];
    bit   m_lvl [NCH];
    bit   m_pend[NCH];
    logic [3:0] m_str;
    logic [3:0] m_pnd;

    multi_strobe_gen #(
        .NUM_CH  (4),
        .CNT_W   (12),
        .DEF_DIV (2500)
    ) dut (
        .sysClk  (sysClk),
        .rst     (rst),
        .cfgWe   (cfgWe),
        .cfgCh   (cfgCh),
        .cfgDiv  (cfgDiv),
        .cfgMode (cfgMode),
        .cfgEn   (cfgEn),
        .cfgNow  (cfgNow),
        .syncAll (syncAll),
        .strobe  (strobe),
        .pending (pending)
    );

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_div[c]  = 2500;
            m_shd[c]  = 2500;
            m_age[c]  = 0;
            m_en[c]   = 1'b0;
            m_sq[c]   = 1'b0;
            m_lvl[c]  = 1'b0;
            m_pend[c] = 1'b0;
        end
        m_str = '0;
        m_pnd = '0;
    endfunction

    function automatic void model_edge();
        bit wr;
        bit live;
        bit fire;
        int nage;
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            wr   = cfgWe && (int'(cfgCh) == c);
            live = m_en[c] && (m_div[c] > 0);
            fire = live && (m_age[c] + 1 == m_div[c])
                   && !syncAll && !(wr && cfgNow);
            if (live)
                nage = (m_age[c] + 1) % m_div[c];
            else
                nage = (m_div[c] == 0) ? 0 : m_age[c];
            if (fire) begin
                m_lvl[c] = !m_lvl[c];
                if (m_pend[c] && !wr) begin
                    m_div[c]  = m_shd[c];
                    m_pend[c] = 1'b0;
                end
            end
            if (wr) begin
                if (cfgMode != m_sq[c])
                    m_lvl[c] = 1'b0;
                m_en[c]  = cfgEn;
                m_sq[c]  = cfgMode;
                m_shd[c] = int'(cfgDiv);
                if (cfgNow || !live) begin
                    m_div[c]  = int'(cfgDiv);
                    nage      = 0;
                    m_pend[c] = 1'b0;
                end else begin
                    m_pend[c] = 1'b1;
                end
            end
            if (syncAll) begin
                nage     = 0;
                m_lvl[c] = 1'b0;
            end
            m_age[c] = nage;
            m_str[c] = m_sq[c] ? m_lvl[c] : fire;
            m_pnd[c] = m_pend[c];
        end
    endfunction

    task automatic tick();
        @(posedge sysClk);
        model_edge();
        #1;
        cfgWe   = 1'b0;
        cfgNow  = 1'b0;
        syncAll = 1'b0;
    endtask

    task automatic wr(input int ch, input int dv, input bit md,
                      input bit en, input bit now);
        cfgWe   = 1'b1;
        cfgCh   = 2'(ch);
        cfgDiv  = 12'(dv);
        cfgMode = md;
        cfgEn   = en;
        cfgNow  = now;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #3;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_vec++;
        if (strobe !== 4'b0 || pending !== 4'b0) begin
            n_err++;
            $display("FAIL reset_out strobe=%b pending=%b want 0000/0000",
                     strobe, pending);
        end
        wr(0, 1, 1'b0, 1'b1, 1'b1);
        tick();
        n_vec++;
        if (strobe !== 4'b0 || pending !== 4'b0) begin
            n_err++;
            $display("FAIL reset_hold strobe=%b pending=%b want 0000/0000",
                     strobe, pending);
        end
        rst = 1'b0;
        tick();
        n_vec++;
        if (strobe !== 4'b0) begin
            n_err++;
            $display("FAIL reset_idle strobe=%b want 0000", strobe);
        end
    endtask

    task automatic test_pulse();
        logic [3:0] exp;
        do_reset();
        wr(0, 4, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp = (k % 4 == 0) ? 4'b0001 : 4'b0000;
            n_vec++;
            if (strobe !== exp || pending !== 4'b0) begin
                n_err++;
                $display("FAIL pulse k=%0d strobe=%b pending=%b want %b/0000",
                         k, strobe, pending, exp);
            end
        end
    endtask

    task automatic test_square();
        logic [3:0] exp;
        do_reset();
        wr(1, 3, 1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp = ((k / 3) % 2 == 1) ? 4'b0010 : 4'b0000;
            n_vec++;
            if (strobe !== exp) begin
                n_err++;
                $display("FAIL square k=%0d strobe=%b want %b",
                         k, strobe, exp);
            end
        end
        wr(1, 0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            n_vec++;
            if (strobe !== 4'b0010 || pending !== 4'b0) begin
                n_err++;
                $display("FAIL div0_hold k=%0d strobe=%b pending=%b want 0010/0000",
                         k, strobe, pending);
            end
        end
    endtask

    task automatic test_div1();
        logic [3:0] exp;
        do_reset();
        wr(2, 1, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_vec++;
            if (strobe !== 4'b0100) begin
                n_err++;
                $display("FAIL div1_pulse k=%0d strobe=%b want 0100", k, strobe);
            end
        end
        wr(3, 1, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) tick();
            exp = (k % 2 == 1) ? 4'b1100 : 4'b0100;
            n_vec++;
            if (strobe !== exp) begin
                n_err++;
                $display("FAIL div1_square k=%0d strobe=%b want %b",
                         k, strobe, exp);
            end
        end
    endtask

    task automatic test_shadow();
        logic [3:0] es;
        logic [3:0] ep;
        do_reset();
        wr(2, 5, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            es = (k % 5 == 0) ? 4'b0100 : 4'b0000;
            n_vec++;
            if (strobe !== es || pending !== 4'b0) begin
                n_err++;
                $display("FAIL shadow_pre k=%0d strobe=%b pending=%b want %b/0000",
                         k, strobe, pending, es);
            end
        end
        wr(2, 2, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (strobe !== 4'b0 || pending !== 4'b0100) begin
            n_err++;
            $display("FAIL shadow_wr strobe=%b pending=%b want 0000/0100",
                     strobe, pending);
        end
        for (int k = 8; k <= 16; k++) begin
            tick();
            es = (k == 10 || (k > 10 && k % 2 == 0)) ? 4'b0100 : 4'b0000;
            ep = (k < 10) ? 4'b0100 : 4'b0000;
            n_vec++;
            if (strobe !== es || pending !== ep) begin
                n_err++;
                $display("FAIL shadow_post k=%0d strobe=%b pending=%b want %b/%b",
                         k, strobe, pending, es, ep);
            end
        end
    endtask

    task automatic test_sync();
        logic [3:0] exp;
        do_reset();
        wr(0, 4, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        wr(1, 4, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        syncAll = 1'b1;
        tick();
        n_vec++;
        if (strobe !== 4'b0) begin
            n_err++;
            $display("FAIL sync_edge strobe=%b want 0000", strobe);
        end
        for (int j = 1; j <= 8; j++) begin
            tick();
            exp = (j % 4 == 0) ? 4'b0011 : 4'b0000;
            n_vec++;
            if (strobe !== exp) begin
                n_err++;
                $display("FAIL sync_align j=%0d strobe=%b want %b",
                         j, strobe, exp);
            end
        end
    endtask

    task automatic test_tc_collision();
        logic [3:0] es;
        logic [3:0] ep;
        do_reset();
        wr(0, 4, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 3; k++) tick();
        wr(0, 2, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (strobe !== 4'b0001 || pending !== 4'b0001) begin
            n_err++;
            $display("FAIL tc_shadow strobe=%b pending=%b want 0001/0001",
                     strobe, pending);
        end
        for (int k = 5; k <= 12; k++) begin
            tick();
            es = (k == 8 || (k >= 10 && k % 2 == 0)) ? 4'b0001 : 4'b0000;
            ep = (k < 8) ? 4'b0001 : 4'b0000;
            n_vec++;
            if (strobe !== es || pending !== ep) begin
                n_err++;
                $display("FAIL tc_shadow_run k=%0d strobe=%b pending=%b want %b/%b",
                         k, strobe, pending, es, ep);
            end
        end
        tick();
        wr(0, 3, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if (strobe !== 4'b0 || pending !== 4'b0) begin
            n_err++;
            $display("FAIL tc_now strobe=%b pending=%b want 0000/0000",
                     strobe, pending);
        end
        for (int k = 15; k <= 20; k++) begin
            tick();
            es = (k == 17 || k == 20) ? 4'b0001 : 4'b0000;
            n_vec++;
            if (strobe !== es) begin
                n_err++;
                $display("FAIL tc_now_run k=%0d strobe=%b want %b",
                         k, strobe, es);
            end
        end
    endtask

    task automatic test_reset_mid();
        int highs;
        do_reset();
        wr(0, 1, 1'b1, 1'b1, 1'b1);
        wr(2, 5, 1'b0, 1'b1, 1'b1);
        tick();
        wr(2, 7, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (strobe !== 4'b0001 || pending !== 4'b0100) begin
            n_err++;
            $display("FAIL mid_pre strobe=%b pending=%b want 0001/0100",
                     strobe, pending);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if (strobe !== 4'b0 || pending !== 4'b0) begin
            n_err++;
            $display("FAIL mid_async strobe=%b pending=%b want 0000/0000",
                     strobe, pending);
        end
        #2;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if (strobe !== 4'b0 || pending !== 4'b0) begin
                n_err++;
                $display("FAIL mid_idle k=%0d strobe=%b pending=%b want 0000/0000",
                         k, strobe, pending);
            end
        end
        wr(3, 2500, 1'b0, 1'b1, 1'b0);
        for (int p = 1; p <= 2; p++) begin
            highs = 0;
            for (int k = 1; k < 2500; k++) begin
                tick();
                if (strobe !== 4'b0) highs++;
            end
            n_vec++;
            if (highs !== 0) begin
                n_err++;
                $display("FAIL long_gap p=%0d early_highs=%0d want 0", p, highs);
            end
            tick();
            n_vec++;
            if (strobe !== 4'b1000) begin
                n_err++;
                $display("FAIL long_edge p=%0d strobe=%b want 1000", p, strobe);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cfgWe   = ($urandom_range(0, 3) == 0);
            cfgCh   = 2'($urandom_range(0, 3));
            cfgDiv  = 12'($urandom_range(0, 7));
            cfgMode = 1'($urandom_range(0, 1));
            cfgEn   = ($urandom_range(0, 7) != 0);
            cfgNow  = 1'($urandom_range(0, 1));
            syncAll = ($urandom_range(0, 24) == 0);
            tick();
            n_vec++;
            if (strobe !== m_str || pending !== m_pnd) begin
                n_err++;
                $display("FAIL random i=%0d strobe=%b pending=%b want %b/%b",
                         i, strobe, pending, m_str, m_pnd);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        cfgWe   = 1'b0;
        cfgCh   = '0;
        cfgDiv  = '0;
        cfgMode = 1'b0;
        cfgEn   = 1'b0;
        cfgNow  = 1'b0;
        syncAll = 1'b0;
        model_reset();
        test_reset();
        test_pulse();
        test_square();
        test_div1();
        test_shadow();
        test_sync();
        test_tc_collision();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
